bcd_timer_n: RTL and testbench

BCD_TIMER_N -- requirements
Module: bcd_timer_n

---
 rtl/bcd_timer_n.sv | 222 ++++++++++++++++++++++
 tb/tb_bcd_timer_n.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_n.sv
// -----------------------------------------------------------------------------
// bcd_timer_n
//
// Purpose:
//   Multi-digit BCD up/down timer with load, start, pause and a one-cycle
//   terminal-count pulse. The count steps by one per qualified tick (en) while
//   running. Counting down stops at all zeros, and counting up stops at all
//   nines.
//
// Optional feature:
//   BCD_TIMER_AUTO_RELOAD_EN -- when defined, the timer does not stop at the
//   terminal value. It stays in RUN and reloads the last loaded preset on the
//   next qualified tick. The DONE state is then unreachable.
//
// Parameters:
//   DIGITS    number of BCD digits (1..8), default 4
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset
//   load      synchronous load of ini_value (highest priority)
//   ini_value preset value, BCD, digit 0 in bits [3:0]; digits > 9 clamp to 9
//   start     start / resume counting
//   pause     suspend counting (start wins when both are high)
//   en        count tick, qualified per cycle
//   dir       0 = count down, 1 = count up
//   value     current BCD count (registered)
//   busy      state is RUN
//   done      state is DONE
//   tc        one-cycle terminal-count pulse (registered)
// -----------------------------------------------------------------------------
module bcd_timer_n #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] ini_value,
  input  logic                start,
  input  logic                pause,
  input  logic                en,
  input  logic                dir,
  output logic [4*DIGITS-1:0] value,
  output logic                busy,
  output logic                done,
  output logic                tc
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Force every digit above 9 down to 9.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      else                    r[4*i +: 4] = v[4*i +: 4];
    end
    return r;
  endfunction

  // BCD +1. A digit wraps 9->0 and carries on only while all lower digits were 9.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // BCD -1. A digit wraps 0->9 and borrows on only while all lower digits were 0.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Terminal value when counting up: every digit 9.
  function automatic logic [W-1:0] all_nines();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  localparam logic [W-1:0] NINES = all_nines();

  state_t       state;
  state_t       state_next;
  logic [W-1:0] value_next;
  logic [W-1:0] loaded;
  logic [W-1:0] stepped;
  logic [W-1:0] term_val;
  logic         tc_next;
  logic         at_term;
  logic         step_hits_term;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [W-1:0] reload;
`endif

  // Step candidate and terminal detection; dir is sampled on the step cycle itself.
  always_comb begin
    loaded         = clamp_bcd(ini_value);
    term_val       = dir ? NINES : {W{1'b0}};
    stepped        = dir ? bcd_inc(value) : bcd_dec(value);
    at_term        = (value == term_val);
    step_hits_term = (stepped == term_val);
  end

  // Next state, next count and terminal-count pulse.
  always_comb begin
    state_next = state;
    value_next = value;
    tc_next    = 1'b0;
    if (load) begin
      value_next = loaded;
      state_next = ST_IDLE;
    end else if (start && (state != ST_RUN)) begin
      // Starting on the terminal value makes no step but still signals tc.
      if (at_term) begin
        tc_next = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        state_next = ST_RUN;
`else
        state_next = ST_DONE;
`endif
      end else begin
        state_next = ST_RUN;
      end
    end else if (state == ST_RUN) begin
      if (en) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        // Sitting on the terminal value: the next tick restarts from the preset.
        if (at_term) begin
          value_next = reload;
        end else begin
          value_next = stepped;
          tc_next    = step_hits_term;
        end
`else
        value_next = stepped;
        if (step_hits_term) begin
          tc_next    = 1'b1;
          state_next = ST_DONE;
        end else begin
          tc_next    = 1'b0;
        end
`endif
      end else begin
        value_next = value;
      end
      // Reaching DONE on this tick takes precedence over a pause request.
      state_next = (pause && !start && (state_next == ST_RUN)) ? ST_PAUSE : state_next;
    end else begin
      value_next = value;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Count, tc pulse and preset registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value  <= {W{1'b0}};
      tc     <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      reload <= {W{1'b0}};
`endif
    end else begin
      value  <= value_next;
      tc     <= tc_next;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      if (load) reload <= loaded;
      else      reload <= reload;
`endif
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

endmodule

// File: tb/tb_bcd_timer_n.sv
module tb_bcd_timer_n;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int M      = 10 ** DIGITS;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [W-1:0] ini_value;
  logic         start;
  logic         pause;
  logic         en;
  logic         dir;
  logic [W-1:0] value;
  logic         busy;
  logic         done;
  logic         tc;

  int n_checks;
  int n_fail;

  bcd_timer_n #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .ini_value(ini_value),
    .start(start), .pause(pause), .en(en), .dir(dir),
    .value(value), .busy(busy), .done(done), .tc(tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         load;
    logic [W-1:0] ini;
    logic         start;
    logic         pause;
    logic         en;
    logic         dir;
    logic [W-1:0] e_value;
    logic         e_busy;
    logic         e_done;
    logic         e_tc;
  } vec_t;

  vec_t vq[$];

  // behavioural model: plain integers, state kept as a small mode number
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  int mval, mreload, mst;
  bit mtc;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int clamp_int(input logic [W-1:0] b);
    int r, d, p;
    r = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      r = r + d * p;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    load = 1'b0; start = 1'b0; pause = 1'b0; en = 1'b0;
  endtask

  task automatic add_vec(input logic l, input logic [W-1:0] ini, input logic s, input logic p,
                         input logic e, input logic d, input logic [W-1:0] ev,
                         input logic eb, input logic ed, input logic et);
    vec_t v;
    v.load = l; v.ini = ini; v.start = s; v.pause = p; v.en = e; v.dir = d;
    v.e_value = ev; v.e_busy = eb; v.e_done = ed; v.e_tc = et;
    vq.push_back(v);
  endtask

  // model of one clock edge, from the inputs currently applied
  task automatic model_step();
    int term;
    term = dir ? (M - 1) : 0;
    mtc  = 1'b0;
    if (load) begin
      mval    = clamp_int(ini_value);
      mreload = mval;
      mst     = S_IDLE;
    end else if (start && mst != S_RUN) begin
      if (mval == term) begin
        mtc = 1'b1;
        mst = AUTO ? S_RUN : S_DONE;
      end else begin
        mst = S_RUN;
      end
    end else if (mst == S_RUN) begin
      if (en) begin
        if (AUTO && mval == term) begin
          mval = mreload;
        end else begin
          mval = dir ? (mval + 1) % M : (mval + M - 1) % M;
          if (mval == term) begin
            mtc = 1'b1;
            if (!AUTO) mst = S_DONE;
          end
        end
      end
      if (pause && !start && mst == S_RUN) mst = S_PAUSE;
    end
  endtask

  initial begin
    int tc_count;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    ini_value = '0;
    dir = 1'b0;
    quiet();
    #12;
    chk("reset.value", 32'(value), 32'h0);
    chk("reset.busy", 32'(busy), 32'h0);
    chk("reset.done", 32'(done), 32'h0);
    chk("reset.tc", 32'(tc), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table: borrow chain, up terminal, clamping, load priority, pause, start-at-terminal
    add_vec(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0999, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 16'h9998, 1'b0, 1'b0, 1'b0, 1'b1, 16'h9998, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h9998, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h9999, AUTO, !AUTO, 1'b1);
    add_vec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, AUTO ? 16'h9998 : 16'h9999, AUTO, !AUTO, 1'b0);
    add_vec(1'b1, 16'hFA32, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9932, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h9932, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h9931, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 16'h0501, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0501, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0501, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0500, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 16'h0042, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0042, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0042, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0042, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0042, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0042, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0042, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0043, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, AUTO, !AUTO, 1'b1);
    add_vec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, AUTO, !AUTO, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      load = vq[i].load; ini_value = vq[i].ini; start = vq[i].start;
      pause = vq[i].pause; en = vq[i].en; dir = vq[i].dir;
      tick();
      chk($sformatf("vec%0d.value", i), 32'(value), 32'(vq[i].e_value));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vq[i].e_busy));
      chk($sformatf("vec%0d.done", i), 32'(done), 32'(vq[i].e_done));
      chk($sformatf("vec%0d.tc", i), 32'(tc), 32'(vq[i].e_tc));
    end

    // full countdown from 0102
    quiet(); dir = 1'b0; load = 1'b1; ini_value = 16'h0102; tick();
    quiet(); start = 1'b1; tick();
    quiet(); en = 1'b1;
    tc_count = 0;
    for (int k = 1; k <= 102; k++) begin
      tick();
      chk($sformatf("down.step%0d", k), 32'(value), 32'(to_bcd(102 - k)));
      tc_count += int'(tc);
    end
    chk("down.tc_count", 32'(tc_count), 32'd1);
    chk("down.done", 32'(done), 32'(!AUTO));
    chk("down.busy", 32'(busy), 32'(AUTO));
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("down.after%0d", k), 32'(value), AUTO ? 32'(to_bcd(103 - k)) : 32'h0);
    end

    // pause and resume
    quiet(); dir = 1'b0; load = 1'b1; ini_value = 16'h0050; tick();
    quiet(); start = 1'b1; tick();
    quiet(); en = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("pause.counted", 32'(value), 32'h0047);
    quiet(); pause = 1'b1; tick();
    quiet(); en = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("pause.held", 32'(value), 32'h0047);
    chk("pause.busy", 32'(busy), 32'h0);
    quiet(); start = 1'b1; tick();
    quiet(); en = 1'b1; tick();
    chk("pause.resumed", 32'(value), 32'h0046);

    // reset in mid-count
    quiet(); load = 1'b1; ini_value = 16'h0100; tick();
    quiet(); start = 1'b1; tick();
    quiet(); en = 1'b1; tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.value", 32'(value), 32'h0);
    chk("midrst.busy", 32'(busy), 32'h0);
    chk("midrst.tc", 32'(tc), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("midrst.idle_value", 32'(value), 32'h0);
    chk("midrst.idle_busy", 32'(busy), 32'h0);
    chk("midrst.idle_tc", 32'(tc), 32'h0);

    // randomized run against the behavioural model
    quiet();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    mval = 0; mreload = 0; mst = S_IDLE; mtc = 1'b0;
    dir = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      load  = ($urandom_range(15) == 0);
      start = ($urandom_range(7) == 0);
      pause = ($urandom_range(7) == 0);
      en    = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) dir = ~dir;
      case ($urandom_range(2))
        0:       ini_value = to_bcd(int'($urandom_range(3)));
        1:       ini_value = to_bcd(M - 1 - int'($urandom_range(3)));
        default: ini_value = W'($urandom);
      endcase
      tick();
      model_step();
      chk($sformatf("rand%0d.value", n), 32'(value), 32'(to_bcd(mval)));
      chk($sformatf("rand%0d.busy", n), 32'(busy), 32'(mst == S_RUN));
      chk($sformatf("rand%0d.done", n), 32'(done), 32'(mst == S_DONE));
      chk($sformatf("rand%0d.tc", n), 32'(tc), 32'(mtc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
